// File: rtl/ped_crossing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ped_crossing_pkg
//  Description : Shared types and default constants for the pedestrian
//                crossing controller (FSM state encoding, default timings).
//  Revision    : 1.0  initial release
// ============================================================================
package ped_crossing_pkg;

  // Width of the crossing FSM state register
  localparam int STATE_W = 2;

  // Default timing parameters (in clock cycles)
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_WALK_CYCLES     = 8;
  localparam int DEF_FLASH_CYCLES    = 6;
  localparam int DEF_CNT_W           = 4;

  // Crossing FSM states
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WALK  = 2'd2,
    ST_CLEAR = 2'd3
  } state_e;

endpackage : ped_crossing_pkg
`default_nettype wire

// File: rtl/ped_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : ped_debounce
//  Description : Two-flop synchronizer for the raw push-button followed by a
//                saturating debounce counter. Emits one registered single-cycle
//                press pulse per accepted (long enough) press.
//  Revision    : 1.0  initial release
// ============================================================================
module ped_debounce
  import ped_crossing_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [CNT_W-1:0] C_DEB    = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] C_DEB_M1 = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_q;
  logic             press_d;

  // Count consecutive synchronized-high cycles, saturating at the threshold;
  // the pulse fires on the single transition into the threshold value.
  always_comb begin
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (!sync_q) begin
      cnt_d = '0;
    end else if (cnt_q != C_DEB) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    press_d = sync_q && (cnt_q == C_DEB_M1);
  end

  // Synchronizer, counter and pulse registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      meta_q  <= btn_i;
      sync_q  <= meta_q;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule : ped_debounce
`default_nettype wire

// File: rtl/ped_crossing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ped_crossing_ctrl
//  Description : Pedestrian endpoint of the stoplight Ped/Sig interface.
//                Debounces the push-button, raises the crossing request,
//                and sequences Walk / flashing Don't-Walk lamps with a
//                countdown. Illegal stoplight signals latch a sticky fault
//                that holds the crossing in a safe Don't-Walk state.
//  Revision    : 1.0  initial release
// ============================================================================
module ped_crossing_ctrl
  import ped_crossing_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int WALK_CYCLES     = DEF_WALK_CYCLES,
  parameter int FLASH_CYCLES    = DEF_FLASH_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Btn,
  input  logic             SigG,
  input  logic             SigY,
  input  logic             SigR,
  output logic             Ped,
  output logic             Walk,
  output logic             DontWalk,
  output logic             Flash,
  output logic             Waiting,
  output logic [CNT_W-1:0] Count,
  output logic             Fault
);

  localparam logic [CNT_W-1:0] C_WALK  = CNT_W'(WALK_CYCLES);
  localparam logic [CNT_W-1:0] C_FLASH = CNT_W'(FLASH_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

  logic             press;
  logic             sig_illegal;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pending_q;
  logic             pending_d;
  logic             fault_q;
  logic             fault_d;

  logic             ped_d;
  logic             walk_d;
  logic             dontwalk_d;
  logic             flash_d;
  logic             waiting_d;
  logic [CNT_W-1:0] count_d;

  ped_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb (
    .CLK     (CLK),
    .RST     (RST),
    .btn_i   (Btn),
    .press_o (press)
  );

  // Legal vehicle signalling means exactly one of G/Y/R is high
  assign sig_illegal = !(SigG ^ SigY ^ SigR) || (SigG && SigY && SigR);

  // State register: FSM state, countdown, pending request and sticky fault
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      fault_q   <= fault_d;
    end
  end

  // Next-state logic; a fault (old or new) overrides every other transition
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    fault_d   = fault_q || sig_illegal;

    if (fault_d) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press) begin
            state_d   = ST_REQ;
            pending_d = 1'b0;
          end
        end
        ST_REQ: begin
          // Presses here are redundant: the request is already up
          if (SigR) begin
            state_d = ST_WALK;
            cnt_d   = C_WALK;
          end
        end
        ST_WALK: begin
          if (press) begin
            pending_d = 1'b1;
          end
          // Abort (red withdrawn) wins over normal countdown expiry
          if (!SigR || (cnt_q == C_ONE)) begin
            state_d = ST_CLEAR;
            cnt_d   = C_FLASH;
          end else begin
            cnt_d = cnt_q - C_ONE;
          end
        end
        ST_CLEAR: begin
          if (press) begin
            pending_d = 1'b1;
          end
          if (cnt_q == C_ONE) begin
            cnt_d = '0;
            // A press arriving on the final clearance cycle is not dropped
            if (pending_q || press) begin
              state_d   = ST_REQ;
              pending_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q - C_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so that every lamp is registered
  always_comb begin
    ped_d      = 1'b0;
    walk_d     = 1'b0;
    dontwalk_d = 1'b1;
    flash_d    = 1'b0;
    waiting_d  = pending_d;
    count_d    = '0;
    case (state_d)
      ST_REQ: begin
        ped_d     = 1'b1;
        waiting_d = 1'b1;
      end
      ST_WALK: begin
        walk_d     = 1'b1;
        dontwalk_d = 1'b0;
        count_d    = cnt_d;
      end
      ST_CLEAR: begin
        // Blink starts lit on entry and toggles every cycle afterwards
        flash_d = (state_q == ST_CLEAR) ? !Flash : 1'b1;
      end
      default: begin
        ped_d = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Ped      <= 1'b0;
      Walk     <= 1'b0;
      DontWalk <= 1'b1;
      Flash    <= 1'b0;
      Waiting  <= 1'b0;
      Count    <= '0;
    end else begin
      Ped      <= ped_d;
      Walk     <= walk_d;
      DontWalk <= dontwalk_d;
      Flash    <= flash_d;
      Waiting  <= waiting_d;
      Count    <= count_d;
    end
  end

  assign Fault = fault_q;

endmodule : ped_crossing_ctrl
`default_nettype wire

// File: tb/tb_ped_crossing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ped_crossing_ctrl
//  Description : Directed self-checking bench for ped_crossing_ctrl with
//                default timing (debounce 4, walk 8, flash 6).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ped_crossing_ctrl;
  import ped_crossing_pkg::*;

  logic       CLK;
  logic       RST;
  logic       Btn;
  logic       SigG;
  logic       SigY;
  logic       SigR;
  logic       Ped;
  logic       Walk;
  logic       DontWalk;
  logic       Flash;
  logic       Waiting;
  logic [3:0] Count;
  logic       Fault;

  int checks;
  int errors;

  ped_crossing_ctrl dut (
    .CLK      (CLK),
    .RST      (RST),
    .Btn      (Btn),
    .SigG     (SigG),
    .SigY     (SigY),
    .SigR     (SigR),
    .Ped      (Ped),
    .Walk     (Walk),
    .DontWalk (DontWalk),
    .Flash    (Flash),
    .Waiting  (Waiting),
    .Count    (Count),
    .Fault    (Fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clocks; inputs change and outputs are sampled on falling edges
  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic set_sig(input logic g, input logic y, input logic r);
    SigG = g;
    SigY = y;
    SigR = r;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ped"},      Ped,      0);
    chk({tag, "_walk"},     Walk,     0);
    chk({tag, "_dontwalk"}, DontWalk, 1);
    chk({tag, "_flash"},    Flash,    0);
    chk({tag, "_waiting"},  Waiting,  0);
    chk({tag, "_count"},    Count,    0);
    chk({tag, "_fault"},    Fault,    0);
  endtask

  // Hold the button for 7 clocks: Ped rises after the 7th edge
  task automatic press_to_req(input string tag);
    Btn = 1'b1;
    step(6);
    chk({tag, "_ped_early"}, Ped, 0);
    step(1);
    chk({tag, "_ped_rise"}, Ped, 1);
    Btn = 1'b0;
  endtask

  initial begin
    logic [4:0] bounce;
    checks = 0;
    errors = 0;
    RST    = 1'b1;
    Btn    = 1'b0;
    set_sig(1'b1, 1'b0, 1'b0);
    step(2);
    chk_reset_vals("rst");
    RST = 1'b0;
    step(1);
    chk_reset_vals("post_rst");

    // Bouncing button never gives 4 consecutive synchronized highs
    bounce = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      Btn = bounce[i];
      step(1);
    end
    Btn = 1'b0;
    step(4);
    chk("bounce_ped", Ped, 0);
    chk("bounce_waiting", Waiting, 0);
    chk("bounce_cnt", int'(dut.u_deb.cnt_q), 0);

    // Clean press: Ped 6 edges after first sample
    press_to_req("press1");
    chk("req_waiting", Waiting, 1);
    chk("req_dontwalk", DontWalk, 1);
    step(3);
    chk("req_hold_ped", Ped, 1);

    // Stoplight G -> Y -> R
    set_sig(1'b0, 1'b1, 1'b0);
    step(1);
    chk("yel_walk", Walk, 0);
    chk("yel_ped", Ped, 1);
    set_sig(1'b0, 1'b0, 1'b1);
    step(1);
    chk("walk_on", Walk, 1);
    chk("walk_ped", Ped, 0);
    chk("walk_dontwalk", DontWalk, 0);
    chk("walk_count8", Count, 8);
    for (int i = 7; i >= 1; i--) begin
      step(1);
      chk($sformatf("walk_count%0d", i), Count, i);
      chk("walk_still", Walk, 1);
    end
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk($sformatf("clr_flash%0d", i), Flash, (i % 2 == 0) ? 1 : 0);
      chk("clr_walk", Walk, 0);
      chk("clr_dontwalk", DontWalk, 1);
    end
    step(1);
    chk("idle_state", int'(dut.state_q), int'(ST_IDLE));
    chk("idle_dontwalk", DontWalk, 1);
    chk("idle_flash", Flash, 0);
    chk("idle_waiting", Waiting, 0);

    // Press during WALK queues a new request
    set_sig(1'b1, 1'b0, 1'b0);
    step(1);
    press_to_req("press2");
    set_sig(1'b0, 1'b0, 1'b1);
    step(1);
    chk("w2_count8", Count, 8);
    chk("w2_waiting0", Waiting, 0);
    Btn = 1'b1;
    step(6);
    chk("w2_waiting_pre", Waiting, 0);
    step(1);
    chk("w2_waiting", Waiting, 1);
    chk("w2_count1", Count, 1);
    Btn = 1'b0;
    step(1);
    chk("w2_clear_flash", Flash, 1);
    chk("w2_clear_waiting", Waiting, 1);
    set_sig(1'b1, 1'b0, 1'b0);
    step(5);
    chk("w2_clear_last", int'(dut.state_q), int'(ST_CLEAR));
    step(1);
    chk("w2_req_ped", Ped, 1);
    chk("w2_req_waiting", Waiting, 1);
    chk("w2_req_walk", Walk, 0);
    set_sig(1'b0, 1'b0, 1'b1);
    step(1);
    chk("w3_walk", Walk, 1);
    chk("w3_count8", Count, 8);
    chk("w3_waiting", Waiting, 0);

    // Abort at count 5
    step(3);
    chk("ab_count5", Count, 5);
    set_sig(1'b1, 1'b0, 1'b0);
    step(1);
    chk("ab_walk", Walk, 0);
    chk("ab_flash", Flash, 1);
    chk("ab_count", Count, 0);
    chk("ab_state", int'(dut.state_q), int'(ST_CLEAR));
    for (int i = 1; i < 6; i++) begin
      step(1);
      chk($sformatf("ab_flash%0d", i), Flash, (i % 2 == 0) ? 1 : 0);
    end
    chk("ab_clear_last", int'(dut.state_q), int'(ST_CLEAR));
    step(1);
    chk("ab_idle", int'(dut.state_q), int'(ST_IDLE));
    chk("ab_idle_waiting", Waiting, 0);

    // Fault during WALK
    press_to_req("press3");
    set_sig(1'b0, 1'b0, 1'b1);
    step(2);
    chk("f_walk_pre", Walk, 1);
    chk("f_count_pre", Count, 7);
    set_sig(1'b1, 1'b0, 1'b1);
    step(1);
    chk("f_fault", Fault, 1);
    chk("f_walk", Walk, 0);
    chk("f_dontwalk", DontWalk, 1);
    chk("f_count", Count, 0);
    set_sig(1'b1, 1'b0, 1'b0);
    Btn = 1'b1;
    step(8);
    chk("f_sticky", Fault, 1);
    chk("f_ped", Ped, 0);
    chk("f_waiting", Waiting, 0);
    chk("f_flash", Flash, 0);
    set_sig(1'b0, 1'b0, 1'b1);
    step(2);
    chk("f_walk_blocked", Walk, 0);
    chk("f_sticky2", Fault, 1);
    Btn = 1'b0;

    // Asynchronous reset clears everything without a clock edge
    #1;
    RST = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    step(1);
    RST = 1'b0;
    step(1);
    chk_reset_vals("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ped_crossing_ctrl
`default_nettype wire

// File: doc/ped_crossing_ctrl.md
# ped_crossing_ctrl

Pedestrian-side endpoint of the stoplight Ped/Sig interface. It debounces a crossing push-button and drives the `Ped` request into the stoplight. It watches `SigG`/`SigY`/`SigR` coming back and runs the Walk / flashing Don't-Walk pedestrian lamps with a countdown. It sits beside the stoplight at the intersection top level, and its outputs feed lamp drivers.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized-high cycles required to accept a press (≥1).
- `WALK_CYCLES`, default 8: length of the Walk phase in clocks (≥1).
- `FLASH_CYCLES`, default 6: length of the flashing Don't-Walk phase in clocks (≥1).
- `CNT_W`, default 4: countdown width. It must hold `max(WALK_CYCLES, FLASH_CYCLES, DEBOUNCE_CYCLES)`.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `Btn` in 1: raw push-button, asynchronous, may bounce.
- `SigG`, `SigY`, `SigR` in 1 each: stoplight vehicle signals (exactly one high when legal).
- `Ped` out 1: crossing request to the stoplight.
- `Walk` out 1: Walk lamp.
- `DontWalk` out 1: Don't-Walk lamp enable.
- `Flash` out 1: blink phase for Don't-Walk during clearance.
- `Waiting` out 1: "request registered" lamp.
- `Count` out `CNT_W`: remaining Walk cycles (0 outside WALK).
- `Fault` out 1: sticky illegal-signal indicator.

## Operation
- `Btn` passes through a 2-flop synchronizer. A debounce counter increments while the synchronized level is high and clears when it is low. A single-cycle `press` pulse fires when the counter reaches `DEBOUNCE_CYCLES`, and the counter saturates there. There is one pulse per held press.
- FSM states are IDLE, REQ, WALK and CLEAR.
- **IDLE:** `DontWalk`=1. A `press` moves the FSM to REQ.
- **REQ:** `Ped`=1, `Waiting`=1, `DontWalk`=1. When `SigR`=1 is sampled, the FSM moves to WALK and the counter loads `WALK_CYCLES`.
- **WALK:** `Walk`=1, `DontWalk`=0, `Count`=counter, and the counter decrements each cycle.
  - When the counter is 1, the next state is CLEAR with the counter loaded to `FLASH_CYCLES`.
  - If `SigR` is sampled 0 during WALK (signal abort), the FSM goes to CLEAR on the next edge.
- **CLEAR:** `DontWalk`=1, and `Flash` toggles every cycle starting at 1. When the counter reaches 1, the next state is REQ if a request is pending, otherwise IDLE.
- A `press` in REQ is ignored, since it is already requested. A `press` in WALK or CLEAR sets `pending`, which is cleared on entry to REQ. `Waiting` = (state==REQ) | `pending`.
- Fault handling:
  - Any cycle with `SigG+SigY+SigR` ≠ 1 sets `Fault`, which stays set until `RST`.
  - While `Fault`=1: the FSM is forced to IDLE, `pending` is cleared, press pulses are ignored, `Ped`=0, `Walk`=0, `Flash`=0, and `DontWalk`=1.
- Fault takes priority over every other transition in the same cycle. Abort (`SigR` low) takes priority over countdown expiry.

## Timing
- All outputs are registered.
- Reset values: `Ped`=0, `Walk`=0, `DontWalk`=1, `Flash`=0, `Waiting`=0, `Count`=0, `Fault`=0. Reset also sets the FSM to IDLE and clears the counters, synchronizer and `pending`.
- Reset mid-operation drops `Ped` and `Walk` asynchronously to the reset values above.
- Press latency: with `Btn` held high and first sampled high at edge k, `press` is high after edge k+1+`DEBOUNCE_CYCLES`, and `Ped`/`Waiting` rise at edge k+2+`DEBOUNCE_CYCLES`.
- `SigR` sampled high at edge m with state REQ gives `Walk`=1 and `Ped`=0 after edge m. `Count` equals `WALK_CYCLES` for that cycle and then decrements by 1 per cycle.
- WALK lasts exactly `WALK_CYCLES` clocks and CLEAR lasts exactly `FLASH_CYCLES` clocks, unless aborted.
- A single-cycle illegal Sig combination at edge f raises `Fault` after edge f.

## Structure
- Package `ped_crossing_pkg`: state enum (IDLE, REQ, WALK, CLEAR), 2-bit state width constant, and default parameter constants.
- Sub-module `ped_debounce` contains the synchronizer, debounce counter and press pulse. It is parameterized by `DEBOUNCE_CYCLES` and `CNT_W`.
- The FSM, countdown, `pending` and fault logic live in the top module.

## Test plan
- Reset, then hold `Btn`=1 from t0 with defaults and `SigG`=1 → `Ped` rises 6 edges after first sampling; `Waiting`=1; `DontWalk`=1.
- Bouncing `Btn` (1,0,1,1,0 pattern, never 4 consecutive highs) → no `Ped`, and the debounce counter returns to 0.
- From REQ, drive `SigG`→`SigY`→`SigR` → `Ped` falls and `Walk`=1 on the edge `SigR` is sampled. `Count` runs 8,7,…,1. Then `Flash` toggles for 6 cycles and the FSM returns to IDLE with `DontWalk`=1.
- Press during WALK → `Waiting` stays 1. After CLEAR the FSM goes directly to REQ, `Ped`=1, and the next `SigR` starts a new Walk.
- `SigR` drops to 0 (`SigG`=1) at Walk count 5 → next edge shows CLEAR, `Walk`=0, `Flash`=1, and the full 6-cycle clearance follows.
- `SigG`=`SigR`=1 for one cycle during WALK → `Fault`=1 and `Walk`=0 next edge. `Fault` persists with legal signals and presses. Asserting `RST` clears all outputs to their reset values.
